// File: rtl/aes_pkg.sv
// aes_pkg: shared types and GF(2^8) helpers for the AES inverse cipher.
//   inv_state_e      - inverse-cipher FSM states
//   xtime / gf_mul   - multiply in GF(2^8), reduction polynomial 0x11B
//   inv_shift_rows   - row k rotated right by k bytes
//   inv_mix_columns  - per-column multiply by circulant {0e,0b,0d,09}
// Byte i of a 128-bit state sits at [127-8i -: 8]; i = row + 4*col.
package aes_pkg;

  localparam int unsigned NR_AES128 = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } inv_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        // destination column c takes the byte from column (c - r) mod 4
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+4-r)%4))) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c)   +: 8];
      a1 = s[8*(14-4*c)   +: 8];
      a2 = s[8*(13-4*c)   +: 8];
      a3 = s[8*(12-4*c)   +: 8];
      o[8*(15-4*c) +: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
      o[8*(14-4*c) +: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
      o[8*(13-4*c) +: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
      o[8*(12-4*c) +: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational AES inverse S-box lookup.
//   iByte - input byte
//   oByte - InvSubBytes(iByte)
module aes_inv_sbox (
  input  logic [7:0] iByte,
  output logic [7:0] oByte
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign oByte = INV_SBOX[iByte];

endmodule

// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher: iterative AES decryptor, one inverse round per clock.
//   iClk, iRst_n       - clock (rising edge), async active-low reset
//   iValid/oReady/iData - ciphertext handshake (byte 0 = [127:120])
//   oKeyAddr/iKey      - round-key read port, keys fetched NR down to 0
//   oValid/iReady/oData - plaintext handshake, oData held until accepted
// Optional build macro AES_INV_DBG_EN adds oBusy (FSM not idle) and
// oRound (key index consumed this cycle).
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int unsigned NR         = NR_AES128,
  parameter int unsigned KEY_ADDR_W = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iValid,
  output logic                  oReady,
  input  logic [127:0]          iData,
  output logic [KEY_ADDR_W-1:0] oKeyAddr,
  input  logic [127:0]          iKey,
  output logic                  oValid,
  input  logic                  iReady,
  output logic [127:0]          oData
`ifdef AES_INV_DBG_EN
  ,
  output logic                  oBusy,
  output logic [KEY_ADDR_W-1:0] oRound
`endif
);

  localparam logic [KEY_ADDR_W-1:0] KEY_NR  = KEY_ADDR_W'(NR);
  localparam logic [KEY_ADDR_W-1:0] KEY_ONE = KEY_ADDR_W'(1);

  inv_state_e            r_fsm,      w_fsm_nxt;
  logic [127:0]          r_state,    w_state_nxt;
  logic [KEY_ADDR_W-1:0] r_key_addr, w_key_addr_nxt;
  logic [127:0]          r_data,     w_data_nxt;
  logic                  r_valid,    w_valid_nxt;

  logic [127:0]          w_isr;
  logic [127:0]          w_isb;

  // InvSubBytes(InvShiftRows(state)) is common to ROUND and FINAL
  assign w_isr = inv_shift_rows(r_state);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .iByte (w_isr[8*g +: 8]),
      .oByte (w_isb[8*g +: 8])
    );
  end

  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_state_nxt    = r_state;
    w_key_addr_nxt = r_key_addr;
    w_data_nxt     = r_data;
    w_valid_nxt    = r_valid;
    case (r_fsm)
      ST_IDLE: begin
        if (iValid) begin
          w_state_nxt    = iData ^ iKey;
          w_key_addr_nxt = KEY_NR - KEY_ONE;
          w_fsm_nxt      = ST_ROUND;
        end
      end
      ST_ROUND: begin
        w_state_nxt    = inv_mix_columns(w_isb ^ iKey);
        w_key_addr_nxt = r_key_addr - KEY_ONE;
        if (r_key_addr == KEY_ONE) w_fsm_nxt = ST_FINAL;
      end
      ST_FINAL: begin
        w_data_nxt     = w_isb ^ iKey;
        w_valid_nxt    = 1'b1;
        w_key_addr_nxt = KEY_NR;
        w_fsm_nxt      = ST_DONE;
      end
      ST_DONE: begin
        if (iReady) begin
          w_valid_nxt = 1'b0;
          w_fsm_nxt   = ST_IDLE;
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_fsm      <= ST_IDLE;
      r_state    <= '0;
      r_key_addr <= KEY_NR;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_state    <= w_state_nxt;
      r_key_addr <= w_key_addr_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  assign oReady   = (r_fsm == ST_IDLE);
  assign oKeyAddr = r_key_addr;
  assign oValid   = r_valid;
  assign oData    = r_data;

`ifdef AES_INV_DBG_EN
  // the key index consumed each cycle is exactly the registered address
  assign oBusy  = (r_fsm != ST_IDLE);
  assign oRound = r_key_addr;
`endif

endmodule
